// File: rtl/spi_master_cfg_if.sv
// Purpose : Bus bundle for spi_master_cfg. It carries the host request and
//           configuration, the SPI pins, and the status/result signals.
// Ports   : master - the SPI master side. It takes start/din/cpol/cpha/lsb_first/div/cs_sel/miso
//                    and drives sclk/mosi/cs_n/dout/busy/done.
//           slave  - the host/peer side, with the opposite directions.
interface spi_master_cfg_if #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned NCS    = 4,
    parameter int unsigned DIVW   = 8
);
    localparam int unsigned CSW = (NCS > 1) ? $clog2(NCS) : 1;

    logic              start;
    logic [DWIDTH-1:0] din;
    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic [DIVW-1:0]   div;
    logic [CSW-1:0]    cs_sel;
    logic              miso;
    logic              sclk;
    logic              mosi;
    logic [NCS-1:0]    cs_n;
    logic [DWIDTH-1:0] dout;
    logic              busy;
    logic              done;

    modport master (
        input  start, din, cpol, cpha, lsb_first, div, cs_sel, miso,
        output sclk, mosi, cs_n, dout, busy, done
    );

    modport slave (
        output start, din, cpol, cpha, lsb_first, div, cs_sel, miso,
        input  sclk, mosi, cs_n, dout, busy, done
    );
endinterface

// File: rtl/spi_master_cfg.sv
// Purpose : Configurable SPI master. It supports all four modes, either bit
//           order, a programmable sclk half-period H = div+1, and NCS chip selects.
// Ports   : clk  - clock. All state changes on its rising edge.
//           rst  - asynchronous active-low reset.
//           bus  - spi_master_cfg_if.master. Carries the request/config inputs,
//                  the SPI pins and the dout/busy/done status.
module spi_master_cfg #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned NCS    = 4,
    parameter int unsigned DIVW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    spi_master_cfg_if.master bus
);
    localparam int unsigned CW  = DIVW + 1;
    localparam int unsigned ECW = $clog2(2 * DWIDTH);

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [ECW-1:0]    r_edge;
    logic [DIVW-1:0]   r_div;
    logic              r_cpha;
    logic              r_lsb;
    logic [DWIDTH-1:0] r_tx;
    logic [DWIDTH-1:0] r_rx;
    logic [DWIDTH-1:0] r_dout;
    logic [NCS-1:0]    r_cs_n;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_busy;
    logic              r_done;

    logic              w_accept;
    logic              w_tick;
    logic              w_edge;
    logic              w_lead;
    logic              w_trail;
    logic              w_last;
    logic              w_finish;
    logic              w_present;
    logic              w_sample;
    logic [DWIDTH-1:0] w_din_ord;
    logic [NCS-1:0]    w_cs_dec;

    function automatic logic [DWIDTH-1:0] bit_rev(input logic [DWIDTH-1:0] v);
        logic [DWIDTH-1:0] r;
        for (int i = 0; i < int'(DWIDTH); i++) begin
            r[i] = v[DWIDTH-1-i];
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_LEAD;
            S_LEAD:  if (w_tick)   w_state_nxt = S_XFER;
            S_XFER:  if (w_last)   w_state_nxt = S_TRAIL;
            S_TRAIL: if (w_finish) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control strobes. r_edge holds the number of sclk edges already issued,
    // so the edge about to happen is r_edge+1. That edge is a leading edge when r_edge is even.
    always_comb begin
        w_tick    = (r_cnt == CW'(r_div));
        w_accept  = (r_state == S_IDLE) && bus.start && !r_busy;
        w_edge    = ((r_state == S_LEAD) || (r_state == S_XFER)) && w_tick;
        w_lead    = w_edge && !r_edge[0];
        w_trail   = w_edge && r_edge[0];
        w_last    = w_edge && (r_edge == ECW'(2 * DWIDTH - 1));
        w_finish  = (r_state == S_TRAIL) && w_tick;
        w_present = r_cpha ? w_lead : (w_trail && !w_last);
        w_sample  = r_cpha ? w_trail : w_lead;
    end

    // The transmit word is put into send order once, at accept time, and then always shifted MSB-first.
    // Chip-select indices that are out of range select nothing.
    always_comb begin
        w_din_ord = bus.lsb_first ? bit_rev(bus.din) : bus.din;
        w_cs_dec  = '1;
        for (int i = 0; i < int'(NCS); i++) begin
            w_cs_dec[i] = (32'(bus.cs_sel) != 32'(i));
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_edge <= '0;
            r_div  <= '0;
            r_cpha <= 1'b0;
            r_lsb  <= 1'b0;
            r_tx   <= '0;
            r_rx   <= '0;
            r_dout <= '0;
            r_cs_n <= '1;
            r_sclk <= 1'b0;
            r_mosi <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_busy <= 1'b1;
                r_cs_n <= w_cs_dec;
                r_sclk <= bus.cpol;
                r_div  <= bus.div;
                r_cpha <= bus.cpha;
                r_lsb  <= bus.lsb_first;
                r_rx   <= '0;
                r_cnt  <= '0;
                r_edge <= '0;
                // In CPHA=0 the first bit goes out together with chip select.
                // In CPHA=1 the first bit waits for edge 1.
                if (bus.cpha) begin
                    r_tx <= w_din_ord;
                end else begin
                    r_tx   <= {w_din_ord[DWIDTH-2:0], 1'b0};
                    r_mosi <= w_din_ord[DWIDTH-1];
                end
            end else if (r_state != S_IDLE) begin
                r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
                if (w_edge) begin
                    r_sclk <= ~r_sclk;
                    r_edge <= r_edge + ECW'(1);
                end
                if (w_present) begin
                    r_mosi <= r_tx[DWIDTH-1];
                    r_tx   <= {r_tx[DWIDTH-2:0], 1'b0};
                end
                if (w_sample) begin
                    r_rx <= {r_rx[DWIDTH-2:0], bus.miso};
                end
                if (w_finish) begin
                    r_busy <= 1'b0;
                    r_cs_n <= '1;
                    r_dout <= r_lsb ? bit_rev(r_rx) : r_rx;
                end
            end
        end
    end

    assign bus.sclk = r_sclk;
    assign bus.mosi = r_mosi;
    assign bus.cs_n = r_cs_n;
    assign bus.dout = r_dout;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_spi_master_cfg.sv
// Purpose : Self-checking bench for spi_master_cfg. It drives a table of
//           directed transfers and hand sequences for reset abort,
//           start-while-busy, back-to-back start and out-of-range chip select.
`timescale 1ns/1ps
module tb_spi_master_cfg;
    localparam int unsigned DW = 8;
    localparam int unsigned NC = 4;
    localparam int unsigned DV = 8;

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic       lsb;
        logic       loop;
        logic       miso;
        logic [7:0] div;
        logic [7:0] din;
        logic [1:0] cs_sel;
        logic [7:0] exp_dout;
        int         exp_low;
        int         exp_period;
        logic       exp_first;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic tb_loop;
    logic tb_miso;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs [7];

    spi_master_cfg_if #(.DWIDTH(DW), .NCS(NC), .DIVW(DV)) sif ();
    spi_master_cfg_if #(.DWIDTH(DW), .NCS(5),  .DIVW(DV)) sif5 ();

    assign sif.miso  = tb_loop ? sif.mosi : tb_miso;
    assign sif5.miso = sif5.mosi;

    spi_master_cfg #(.DWIDTH(DW), .NCS(NC), .DIVW(DV)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.master)
    );

    spi_master_cfg #(.DWIDTH(DW), .NCS(5), .DIVW(DV)) u_dut5 (
        .clk (clk),
        .rst (rst),
        .bus (sif5.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int         low = 0;
        int         rises = 0;
        int         cs_bad = 0;
        int         busy_bad = 0;
        int         ntr = 0;
        int         t_first = -1;
        int         t_r1 = -1;
        int         t_r2 = -1;
        logic       idle_sclk;
        logic       prev_sclk;
        logic       first_bit = 1'b0;
        logic [3:0] exp_cs;
        logic [7:0] dout_done = 8'h00;
        bit         fin = 1'b0;
        string      p;
        p = $sformatf("v%0d_", idx);
        exp_cs = 4'hF;
        exp_cs[v.cs_sel] = 1'b0;
        @(negedge clk);
        sif.cpol = v.cpol; sif.cpha = v.cpha; sif.lsb_first = v.lsb;
        sif.div = v.div; sif.din = v.din; sif.cs_sel = v.cs_sel;
        tb_loop = v.loop; tb_miso = v.miso;
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        idle_sclk = sif.sclk;
        prev_sclk = sif.sclk;
        for (int c = 0; c < v.exp_low + 50 && !fin; c++) begin
            if (c > 0) @(negedge clk);
            if (sif.done) begin
                fin = 1'b1;
                dout_done = sif.dout;
                chk({p, "busy_at_done"}, sif.busy, 0);
            end else begin
                if (sif.cs_n[v.cs_sel] == 1'b0) low++;
                if (sif.cs_n != exp_cs) cs_bad++;
                if (!sif.busy) busy_bad++;
                if (sif.sclk != prev_sclk) begin
                    ntr++;
                    if (ntr == 1) begin
                        t_first   = c;
                        first_bit = sif.mosi;
                    end
                    if (sif.sclk) begin
                        rises++;
                        if (rises == 1) t_r1 = c;
                        else if (rises == 2) t_r2 = c;
                    end
                end
                prev_sclk = sif.sclk;
            end
        end
        chk({p, "done_seen"}, fin, 1);
        chk({p, "dout"}, dout_done, v.exp_dout);
        chk({p, "cs_low_cycles"}, low, v.exp_low);
        chk({p, "sclk_rises"}, rises, 8);
        chk({p, "sclk_period"}, t_r2 - t_r1, v.exp_period);
        chk({p, "sclk_idle"}, idle_sclk, v.cpol);
        chk({p, "edge1_time"}, t_first, int'(v.div) + 1);
        chk({p, "first_bit"}, first_bit, v.exp_first);
        chk({p, "cs_pattern"}, cs_bad, 0);
        chk({p, "busy_low"}, busy_bad, 0);
        @(negedge clk);
        chk({p, "done_width"}, sif.done, 0);
        chk({p, "dout_hold"}, sif.dout, v.exp_dout);
    endtask

    initial begin
        int         ntr;
        int         dones;
        int         cs_bad;
        int         t_done;
        int         busy_seen;
        bit         got;
        bit         fin;
        logic       prev;
        logic [7:0] dout1;

        vecs[0] = '{cpol:1'b0, cpha:1'b0, lsb:1'b0, loop:1'b1, miso:1'b0, div:8'd0,   din:8'hA5, cs_sel:2'd0,
                    exp_dout:8'hA5, exp_low:17,   exp_period:2,   exp_first:1'b1};
        vecs[1] = '{cpol:1'b1, cpha:1'b1, lsb:1'b0, loop:1'b0, miso:1'b1, div:8'd3,   din:8'h3C, cs_sel:2'd0,
                    exp_dout:8'hFF, exp_low:68,   exp_period:8,   exp_first:1'b0};
        vecs[2] = '{cpol:1'b0, cpha:1'b1, lsb:1'b1, loop:1'b1, miso:1'b0, div:8'd1,   din:8'h01, cs_sel:2'd1,
                    exp_dout:8'h01, exp_low:34,   exp_period:4,   exp_first:1'b1};
        vecs[3] = '{cpol:1'b1, cpha:1'b0, lsb:1'b1, loop:1'b1, miso:1'b0, div:8'd0,   din:8'h96, cs_sel:2'd3,
                    exp_dout:8'h96, exp_low:17,   exp_period:2,   exp_first:1'b0};
        vecs[4] = '{cpol:1'b0, cpha:1'b0, lsb:1'b0, loop:1'b0, miso:1'b0, div:8'd2,   din:8'hFF, cs_sel:2'd0,
                    exp_dout:8'h00, exp_low:51,   exp_period:6,   exp_first:1'b1};
        vecs[5] = '{cpol:1'b0, cpha:1'b1, lsb:1'b0, loop:1'b1, miso:1'b0, div:8'd0,   din:8'hC3, cs_sel:2'd2,
                    exp_dout:8'hC3, exp_low:17,   exp_period:2,   exp_first:1'b1};
        vecs[6] = '{cpol:1'b0, cpha:1'b0, lsb:1'b0, loop:1'b1, miso:1'b0, div:8'd255, din:8'h5A, cs_sel:2'd1,
                    exp_dout:8'h5A, exp_low:4352, exp_period:512, exp_first:1'b0};

        rst = 1'b0;
        tb_loop = 1'b1; tb_miso = 1'b0;
        sif.start = 1'b0; sif.din = '0; sif.cpol = 1'b0; sif.cpha = 1'b0;
        sif.lsb_first = 1'b0; sif.div = '0; sif.cs_sel = '0;
        sif5.start = 1'b0; sif5.din = '0; sif5.cpol = 1'b0; sif5.cpha = 1'b0;
        sif5.lsb_first = 1'b0; sif5.div = '0; sif5.cs_sel = '0;

        // Values held during reset
        repeat (3) @(negedge clk);
        chk("rst_busy", sif.busy, 0);
        chk("rst_done", sif.done, 0);
        chk("rst_cs_n", sif.cs_n, 4'hF);
        chk("rst_sclk", sif.sclk, 0);
        chk("rst_mosi", sif.mosi, 0);
        chk("rst_dout", sif.dout, 0);
        chk("rst_cs_n_ncs5", sif5.cs_n, 5'h1F);

        // sclk stays 0 until the first accepted start, whatever cpol says
        rst = 1'b1;
        sif.cpol = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_sclk", sif.sclk, 0);

        // Abort with reset at sclk edge 5
        sif.cpol = 1'b0; sif.cpha = 1'b0; sif.lsb_first = 1'b0; sif.div = 8'd1;
        sif.din = 8'hA5; sif.cs_sel = 2'd0; tb_loop = 1'b1;
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        prev = sif.sclk; ntr = 0; got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (sif.sclk != prev) begin
                ntr++;
                prev = sif.sclk;
            end
            if (ntr == 5) got = 1'b1;
        end
        chk("abort_edge5_reached", got, 1);
        rst = 1'b0;
        #1;
        chk("abort_cs_n", sif.cs_n, 4'hF);
        chk("abort_sclk", sif.sclk, 0);
        chk("abort_busy", sif.busy, 0);
        chk("abort_mosi", sif.mosi, 0);
        chk("abort_dout", sif.dout, 0);
        @(negedge clk);
        rst = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (sif.done) dones++;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_dout_after", sif.dout, 0);

        // Table of directed transfers
        foreach (vecs[i]) run_vec(i, vecs[i]);

        // start held high through the transfer with the config inputs scrambled;
        // the start seen in the done cycle launches the next transfer
        @(negedge clk);
        sif.cs_sel = 2'd2; sif.din = 8'h3C; sif.cpol = 1'b0; sif.cpha = 1'b0;
        sif.lsb_first = 1'b0; sif.div = 8'd0; tb_loop = 1'b1;
        sif.start = 1'b1;
        @(negedge clk);
        sif.din = 8'h00; sif.cpol = 1'b1; sif.cpha = 1'b1; sif.lsb_first = 1'b1;
        sif.div = 8'd7; sif.cs_sel = 2'd0;
        fin = 1'b0; t_done = -1; cs_bad = 0; dones = 0; dout1 = 8'h00;
        for (int c = 0; c < 100 && !fin; c++) begin
            if (c > 0) @(negedge clk);
            if (sif.done) begin
                fin = 1'b1;
                t_done = c;
                dones++;
                dout1 = sif.dout;
                sif.cs_sel = 2'd2; sif.din = 8'hC3; sif.cpol = 1'b0; sif.cpha = 1'b0;
                sif.lsb_first = 1'b0; sif.div = 8'd0;
            end else if (sif.cs_n != 4'b1011) begin
                cs_bad++;
            end
        end
        chk("rep_done_time", t_done, 17);
        chk("rep_dout1", dout1, 8'h3C);
        chk("rep_cs_only2", cs_bad, 0);
        @(negedge clk);
        sif.start = 1'b0;
        chk("rep_restart_busy", sif.busy, 1);
        chk("rep_restart_cs", sif.cs_n, 4'b1011);
        fin = 1'b0;
        for (int c = 0; c < 100 && !fin; c++) begin
            @(negedge clk);
            if (sif.done) begin
                fin = 1'b1;
                dones++;
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (sif.done) dones++;
        end
        chk("rep_done_total", dones, 2);
        chk("rep_dout2", sif.dout, 8'hC3);

        // Out-of-range chip select on a 5-select instance
        @(negedge clk);
        sif5.cs_sel = 3'd5; sif5.din = 8'h5A; sif5.cpol = 1'b0; sif5.cpha = 1'b0;
        sif5.lsb_first = 1'b0; sif5.div = 8'd0;
        sif5.start = 1'b1;
        @(negedge clk);
        sif5.start = 1'b0;
        dones = 0; cs_bad = 0; busy_seen = 0;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) @(negedge clk);
            if (sif5.done) dones++;
            if (sif5.busy) busy_seen = 1;
            if (sif5.cs_n != 5'h1F) cs_bad++;
        end
        chk("ncs5_cs_none", cs_bad, 0);
        chk("ncs5_busy_seen", busy_seen, 1);
        chk("ncs5_done_once", dones, 1);
        chk("ncs5_dout", sif5.dout, 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
